// File: rtl/sa_seq_ctrl.sv
// Sequencer for a weight-stationary systolic array: weight-load handshake, X feeding with bubbles,
// and a valid-tag pipeline that picks real results off the bottom row. Optional macro: SA_SEQ_CTRL_PERF_EN.
`timescale 1ns/1ps
module sa_seq_ctrl #(
  parameter int S     = 64,
  parameter int COLS  = 64,
  parameter int LAT   = 127,
  parameter int ROW_W = 16
) (
  input  logic                 I_CLK,
  input  logic                 I_RST,
  input  logic                 I_CMD_VLD,
  output logic                 O_CMD_RDY,
  input  logic [ROW_W-1:0]     I_CMD_ROWS,
  output logic                 O_W_REQ,
  input  logic                 I_W_ACK,
  input  logic                 I_X_VLD,
  output logic                 O_X_RDY,
  input  logic [S*16-1:0]      I_X_DATA,
  output logic                 O_SA_START,
  output logic                 O_SA_END,
  input  logic                 I_SA_SHIFT,
  output logic [S*16-1:0]      O_SA_X,
  input  logic [COLS*16-1:0]   I_SA_OUT,
  output logic                 O_RES_VLD,
  output logic [COLS*16-1:0]   O_RES_DATA,
  output logic                 O_BUSY,
  output logic                 O_DONE
`ifdef SA_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0]          O_PERF_CYC,
  output logic [31:0]          O_PERF_BUB
`endif
);

  typedef enum logic [2:0] {ST_IDLE, ST_WLOAD, ST_START, ST_FEED, ST_DRAIN, ST_FIN} state_t;

  state_t                state_reg, state_next;
  logic [ROW_W-1:0]      rows_reg, accepted_reg, inserted_reg, results_reg;
  logic                  stage_full_reg;
  logic [S*16-1:0]       stage_reg, sa_x_reg;
  logic [COLS*16-1:0]    res_data_reg;
  logic                  res_vld_reg;
  logic [LAT-1:0]        tag_reg, tag_shift;
  logic                  cmd_hs, shift_en, x_rdy, x_hs;

  assign cmd_hs   = (state_reg == ST_IDLE) && I_CMD_VLD;
  assign shift_en = I_SA_SHIFT && ((state_reg == ST_FEED) || (state_reg == ST_DRAIN));
  assign x_rdy    = (state_reg == ST_FEED) && !stage_full_reg && (accepted_reg < rows_reg);
  assign x_hs     = I_X_VLD && x_rdy;

  // Bit 0 takes the staging-full flag: a real vector is tagged 1, a bubble 0.
  assign tag_shift[0] = stage_full_reg;
  generate
    for (genvar gi = 1; gi < LAT; gi++) begin : g_tag
      assign tag_shift[gi] = tag_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge I_CLK) begin
    if (I_RST) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (I_CMD_VLD) state_next = (I_CMD_ROWS == '0) ? ST_FIN : ST_WLOAD;
      ST_WLOAD: if (I_W_ACK) state_next = ST_START;
      ST_START: state_next = ST_FEED;
      ST_FEED:  if (inserted_reg == rows_reg) state_next = ST_DRAIN;
      ST_DRAIN: if (results_reg == rows_reg) state_next = ST_FIN;
      ST_FIN:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    O_CMD_RDY  = (state_reg == ST_IDLE);
    O_BUSY     = (state_reg != ST_IDLE);
    O_W_REQ    = (state_reg == ST_WLOAD);
    O_SA_START = (state_reg == ST_START);
    O_SA_END   = (state_reg == ST_FIN) && (rows_reg != '0);
    O_DONE     = (state_reg == ST_FIN);
    O_X_RDY    = x_rdy;
    O_SA_X     = sa_x_reg;
    O_RES_VLD  = res_vld_reg;
    O_RES_DATA = res_data_reg;
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      rows_reg       <= '0;
      accepted_reg   <= '0;
      inserted_reg   <= '0;
      results_reg    <= '0;
      stage_full_reg <= 1'b0;
      stage_reg      <= '0;
      sa_x_reg       <= '0;
      res_data_reg   <= '0;
      res_vld_reg    <= 1'b0;
      tag_reg        <= '0;
    end else begin
      res_vld_reg <= 1'b0;
      if (cmd_hs) begin
        rows_reg     <= I_CMD_ROWS;
        accepted_reg <= '0;
        inserted_reg <= '0;
        results_reg  <= '0;
      end
      if ((state_reg == ST_WLOAD) && I_W_ACK) begin
        tag_reg        <= '0;
        stage_full_reg <= 1'b0;
      end
      // A handshake only happens with the stage empty, so it never collides with a drain.
      if (x_hs) begin
        stage_reg      <= I_X_DATA;
        stage_full_reg <= 1'b1;
        accepted_reg   <= accepted_reg + ROW_W'(1);
      end else if (shift_en && stage_full_reg) begin
        stage_full_reg <= 1'b0;
      end
      if (shift_en) begin
        sa_x_reg <= stage_full_reg ? stage_reg : '0;
        tag_reg  <= tag_shift;
        if (stage_full_reg) inserted_reg <= inserted_reg + ROW_W'(1);
        if (tag_reg[LAT-1]) begin
          res_data_reg <= I_SA_OUT;
          res_vld_reg  <= 1'b1;
          results_reg  <= results_reg + ROW_W'(1);
        end
      end
    end
  end

`ifdef SA_SEQ_CTRL_PERF_EN
  logic [31:0] perf_cyc_reg, perf_bub_reg;

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      perf_cyc_reg <= '0;
      perf_bub_reg <= '0;
    end else if (cmd_hs) begin
      perf_cyc_reg <= '0;
      perf_bub_reg <= '0;
    end else begin
      if ((state_reg != ST_IDLE) && (perf_cyc_reg != '1))
        perf_cyc_reg <= perf_cyc_reg + 32'd1;
      if (shift_en && (state_reg == ST_FEED) && !stage_full_reg && (perf_bub_reg != '1))
        perf_bub_reg <= perf_bub_reg + 32'd1;
    end
  end

  assign O_PERF_CYC = perf_cyc_reg;
  assign O_PERF_BUB = perf_bub_reg;
`endif

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// Directed bench for sa_seq_ctrl: small array (S=4, COLS=4, LAT=3), shift every 5 clocks,
// expected results hand-derived from the shift schedule.
`timescale 1ns/1ps
module tb_sa_seq_ctrl;
  localparam int S = 4, COLS = 4, LAT = 3, ROW_W = 16;

  logic               I_CLK = 1'b0, I_RST = 1'b1;
  logic               I_CMD_VLD = 1'b0, O_CMD_RDY;
  logic [ROW_W-1:0]   I_CMD_ROWS = '0;
  logic               O_W_REQ, I_W_ACK = 1'b0;
  logic               I_X_VLD = 1'b0, O_X_RDY;
  logic [S*16-1:0]    I_X_DATA = '0;
  logic               O_SA_START, O_SA_END, I_SA_SHIFT = 1'b0;
  logic [S*16-1:0]    O_SA_X;
  logic [COLS*16-1:0] I_SA_OUT = '0;
  logic               O_RES_VLD;
  logic [COLS*16-1:0] O_RES_DATA;
  logic               O_BUSY, O_DONE;
`ifdef SA_SEQ_CTRL_PERF_EN
  logic [31:0]        perf_cyc, perf_bub;
`endif

  sa_seq_ctrl #(.S(S), .COLS(COLS), .LAT(LAT), .ROW_W(ROW_W)) dut (
    .I_CLK(I_CLK), .I_RST(I_RST),
    .I_CMD_VLD(I_CMD_VLD), .O_CMD_RDY(O_CMD_RDY), .I_CMD_ROWS(I_CMD_ROWS),
    .O_W_REQ(O_W_REQ), .I_W_ACK(I_W_ACK),
    .I_X_VLD(I_X_VLD), .O_X_RDY(O_X_RDY), .I_X_DATA(I_X_DATA),
    .O_SA_START(O_SA_START), .O_SA_END(O_SA_END), .I_SA_SHIFT(I_SA_SHIFT),
    .O_SA_X(O_SA_X), .I_SA_OUT(I_SA_OUT),
    .O_RES_VLD(O_RES_VLD), .O_RES_DATA(O_RES_DATA),
    .O_BUSY(O_BUSY), .O_DONE(O_DONE)
`ifdef SA_SEQ_CTRL_PERF_EN
    , .O_PERF_CYC(perf_cyc), .O_PERF_BUB(perf_bub)
`endif
  );

  always #5 I_CLK = ~I_CLK;

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] xvec(input int i);
    xvec = {16'h1100 + 16'(i), 16'h2200 + 16'(i), 16'h3300 + 16'(i), 16'h4400 + 16'(i)};
  endfunction

  function automatic logic [63:0] res_val(input int k);
    res_val = {16'h5500 + 16'(k), 16'h6600 + 16'(k), 16'h7700 + 16'(k), 16'h8800 + 16'(k)};
  endfunction

  // scoreboard of one command
  int          p, sh_cnt, xi, n_vec, wreq_seen, start_seen, end_seen, done_seen, end_with_done, res_n, rdy_bad;
  logic        shifting, stall;
  int          res_sh [8];
  logic [63:0] res_d [8];
  logic [63:0] sax_log [16];

  task automatic clear_sb(input int nv, input logic st);
    p = 0; sh_cnt = 0; xi = 0; n_vec = nv; stall = st; shifting = 1'b0;
    wreq_seen = 0; start_seen = 0; end_seen = 0; done_seen = 0; end_with_done = 0;
    res_n = 0; rdy_bad = 0;
    for (int i = 0; i < 16; i++) sax_log[i] = 'x;
  endtask

  // One clock: drive source/array stimulus, step, then record what the DUT shows.
  task automatic cyc();
    logic hs;
    I_X_VLD  = (xi < n_vec) && !(stall && xi == 1 && sh_cnt < 2);
    I_X_DATA = xvec(xi);
    I_SA_SHIFT = shifting && (p % 5 == 4);
    if (I_SA_SHIFT) begin
      sh_cnt++;
      I_SA_OUT = res_val(sh_cnt);
    end
    I_W_ACK = O_W_REQ && (wreq_seen == 2);
    hs = I_X_VLD && O_X_RDY;
    @(posedge I_CLK); #1;
    if (hs) xi++;
    p++;
    if (O_W_REQ) wreq_seen++;
    if (O_SA_START) begin start_seen++; shifting = 1'b1; p = 0; end
    if (O_SA_END) end_seen++;
    if (O_DONE) begin
      done_seen++;
      if (O_SA_END) end_with_done++;
      shifting = 1'b0;
    end
    if (O_RES_VLD && res_n < 8) begin
      res_sh[res_n] = sh_cnt;
      res_d[res_n]  = O_RES_DATA;
      res_n++;
    end
    if (I_SA_SHIFT && sh_cnt < 16) sax_log[sh_cnt] = O_SA_X;
    if (O_BUSY && O_CMD_RDY) rdy_bad++;
    I_SA_SHIFT = 1'b0;
    I_W_ACK    = 1'b0;
  endtask

  task automatic start_cmd(input int rows);
    I_CMD_ROWS = 16'(rows);
    I_CMD_VLD  = 1'b1;
    cyc();
    I_CMD_VLD  = 1'b0;
  endtask

  task automatic run_to_done(input string tag);
    int b = 0;
    while (done_seen == 0 && b < 500) begin
      cyc();
      b++;
    end
    check({tag, "_done"}, 64'(done_seen), 64'd1);
    $display("cmd %s: shifts=%0d results=%0d cycles=%0d", tag, sh_cnt, res_n, b);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_rdy"}, 64'(O_CMD_RDY), 64'd1);
    check({tag, "_w_req"},   64'(O_W_REQ),   64'd0);
    check({tag, "_start"},   64'(O_SA_START), 64'd0);
    check({tag, "_end"},     64'(O_SA_END),  64'd0);
    check({tag, "_res_vld"}, 64'(O_RES_VLD), 64'd0);
    check({tag, "_busy"},    64'(O_BUSY),    64'd0);
    check({tag, "_done_o"},  64'(O_DONE),    64'd0);
    check({tag, "_x_rdy"},   64'(O_X_RDY),   64'd0);
    check({tag, "_sa_x"},    O_SA_X,         64'd0);
    check({tag, "_res_data"}, O_RES_DATA,    64'd0);
  endtask

  initial begin
    // reset
    clear_sb(0, 1'b0);
    I_RST = 1'b1;
    cyc(); cyc();
    check_reset_outputs("rst");
    I_RST = 1'b0;

    // stray shift and ack in IDLE
    I_SA_SHIFT = 1'b1; I_W_ACK = 1'b1;
    @(posedge I_CLK); #1;
    I_SA_SHIFT = 1'b0; I_W_ACK = 1'b0;
    check("stray_busy", 64'(O_BUSY), 64'd0);
    check("stray_w_req", 64'(O_W_REQ), 64'd0);
    check("stray_res_vld", 64'(O_RES_VLD), 64'd0);
    check("stray_cmd_rdy", 64'(O_CMD_RDY), 64'd1);

    // basic run, ROWS=3, X always valid
    clear_sb(3, 1'b0);
    start_cmd(3);
    check("basic_w_req_after_accept", 64'(O_W_REQ), 64'd1);
    run_to_done("basic");
    check("basic_w_req_cycles", 64'(wreq_seen), 64'd2);
    check("basic_start_cnt", 64'(start_seen), 64'd1);
    check("basic_end_cnt", 64'(end_seen), 64'd1);
    check("basic_end_with_done", 64'(end_with_done), 64'd1);
    check("basic_res_n", 64'(res_n), 64'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("basic_res%0d_shift", i), 64'(res_sh[i]), 64'(4 + i));
      check($sformatf("basic_res%0d_data", i), res_d[i], res_val(4 + i));
      check($sformatf("basic_sax%0d", i + 1), sax_log[i + 1], xvec(i));
    end
    check("basic_sax4_zero", sax_log[4], 64'd0);
`ifdef SA_SEQ_CTRL_PERF_EN
    check("basic_perf_bub", 64'(perf_bub), 64'd0);
`endif
    cyc();
    check("basic_idle_rdy", 64'(O_CMD_RDY), 64'd1);
    check("basic_idle_busy", 64'(O_BUSY), 64'd0);

    // source stall: second vector only after shift 2
    clear_sb(3, 1'b1);
    start_cmd(3);
    run_to_done("stall");
    check("stall_res_n", 64'(res_n), 64'd3);
    check("stall_res0_shift", 64'(res_sh[0]), 64'd4);
    check("stall_res1_shift", 64'(res_sh[1]), 64'd6);
    check("stall_res2_shift", 64'(res_sh[2]), 64'd7);
    check("stall_res1_data", res_d[1], res_val(6));
    check("stall_res2_data", res_d[2], res_val(7));
    check("stall_sax1", sax_log[1], xvec(0));
    check("stall_sax2_bubble", sax_log[2], 64'd0);
    check("stall_sax3", sax_log[3], xvec(1));
    check("stall_sax4", sax_log[4], xvec(2));
    check("stall_end_cnt", 64'(end_seen), 64'd1);
`ifdef SA_SEQ_CTRL_PERF_EN
    check("stall_perf_bub", 64'(perf_bub), 64'd1);
`endif
    cyc();

    // ROWS=0
    clear_sb(0, 1'b0);
    start_cmd(0);
    check("zero_done", 64'(O_DONE), 64'd1);
    check("zero_end", 64'(O_SA_END), 64'd0);
    check("zero_w_req", 64'(O_W_REQ), 64'd0);
    check("zero_busy", 64'(O_BUSY), 64'd1);
    cyc();
    check("zero_idle_rdy", 64'(O_CMD_RDY), 64'd1);
    check("zero_idle_done", 64'(O_DONE), 64'd0);
    check("zero_start_cnt", 64'(start_seen), 64'd0);
    check("zero_w_req_cnt", 64'(wreq_seen), 64'd0);

    // busy rejection: command valid held through the run
    clear_sb(1, 1'b0);
    start_cmd(1);
    I_CMD_VLD = 1'b1; I_CMD_ROWS = 16'd5;
    run_to_done("busy");
    check("busy_rdy_while_busy", 64'(rdy_bad), 64'd0);
    check("busy_res_n", 64'(res_n), 64'd1);
    check("busy_res0_shift", 64'(res_sh[0]), 64'd4);
    cyc();
    check("busy_after_done_rdy", 64'(O_CMD_RDY), 64'd1);
    cyc();
    check("busy_second_accepted", 64'(O_W_REQ), 64'd1);
    I_CMD_VLD = 1'b0;
    I_RST = 1'b1;
    cyc();
    I_RST = 1'b0;

    // reset mid-DRAIN with one result pending
    clear_sb(2, 1'b0);
    start_cmd(2);
    for (int b = 0; b < 500 && res_n == 0; b++) cyc();
    check("mid_res_n_before_rst", 64'(res_n), 64'd1);
    shifting = 1'b0;
    I_RST = 1'b1;
    cyc();
    I_RST = 1'b0;
    check_reset_outputs("mid_rst");
    for (int i = 0; i < 3; i++) cyc();
    check("mid_no_done", 64'(done_seen), 64'd0);
    check("mid_no_end", 64'(end_seen), 64'd0);

    clear_sb(2, 1'b0);
    start_cmd(2);
    run_to_done("after_rst");
    check("after_rst_res_n", 64'(res_n), 64'd2);
    check("after_rst_res0_shift", 64'(res_sh[0]), 64'd4);
    check("after_rst_res1_shift", 64'(res_sh[1]), 64'd5);
    check("after_rst_res1_data", res_d[1], res_val(5));
    check("after_rst_end_cnt", 64'(end_seen), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
